cpu_pipeline_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage core. It merges stall requests from fetch, decode (load-use), the multi-cycle EX unit and the memory stage into one per-register stall vector. It runs the multi-cycle-operation countdown FSM and turns exception/ERET flush requests into a flush pulse plus a redirect PC. It also keeps stall and flush performance counters.

---
 rtl/cpu_pipeline_ctrl_pkg.sv | 19 +
 rtl/cpu_pipeline_ctrl_if.sv | 36 +++
 rtl/cpu_pipeline_ctrl_multi_seq.sv | 84 ++++++++
 rtl/cpu_pipeline_ctrl.sv | 77 +++++++
 tb/tb_cpu_pipeline_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipeline_ctrl_pkg.sv
// Shared pipeline-control types: per-register stall vectors and multi-cycle FSM states.
package cpu_defs;

    typedef logic [4:0] Stall_t;

    // Bit k holds pipeline register k: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
    localparam Stall_t STALL_NONE  = 5'b00000;
    localparam Stall_t STALL_IF    = 5'b00001;
    localparam Stall_t STALL_ID    = 5'b00011;
    localparam Stall_t STALL_MULTI = 5'b00111;
    localparam Stall_t STALL_MEM   = 5'b01111;

    typedef enum logic [1:0] {
        MULTI_IDLE,
        MULTI_BUSY,
        MULTI_DONE
    } MultiState_t;

endpackage

// File: rtl/cpu_pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and the central sequencer.
interface cpu_pipeline_ctrl_if
    import cpu_defs::*;
#(
    parameter int MULTI_CNT_W = 6,
    parameter int PERF_W      = 32
);
    logic                   stallreq_if;
    logic                   stallreq_id;
    logic                   stallreq_mem;
    logic                   multi_start;
    logic [MULTI_CNT_W-1:0] multi_cycles;
    logic                   flush_req;
    logic [31:0]            flush_pc;

    Stall_t                 stall;
    logic                   flush;
    logic [31:0]            redirect_pc;
    logic                   multi_busy;
    logic                   multi_done;
    logic [PERF_W-1:0]      stall_cycles;
    logic [PERF_W-1:0]      flush_count;

    modport master (
        output stallreq_if, stallreq_id, stallreq_mem, multi_start, multi_cycles,
               flush_req, flush_pc,
        input  stall, flush, redirect_pc, multi_busy, multi_done, stall_cycles, flush_count
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_mem, multi_start, multi_cycles,
               flush_req, flush_pc,
        output stall, flush, redirect_pc, multi_busy, multi_done, stall_cycles, flush_count
    );

endinterface

// File: rtl/cpu_pipeline_ctrl_multi_seq.sv
// Multi-cycle EX operation countdown: stalls for N cycles (N=0 treated as 1), then one done cycle.
module cpu_multi_seq
    import cpu_defs::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             freeze,
    input  logic             abort,
    output logic             busy,
    output logic             stall_req,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = 1;

    MultiState_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff;
    logic             launch;

    always_comb begin
        eff    = (cycles == '0) ? ONE : cycles;
        launch = (state == MULTI_IDLE) && start && !abort;
    end

    // Start cycle already counts as the first stall cycle, hence the N-1 load.
    always_comb begin
        busy      = 1'b0;
        stall_req = 1'b0;
        done      = 1'b0;
        if (!rst) begin
            case (state)
                MULTI_IDLE: begin
                    busy      = launch;
                    stall_req = launch;
                end
                MULTI_BUSY: begin
                    busy      = 1'b1;
                    stall_req = 1'b1;
                end
                MULTI_DONE: done = !abort;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MULTI_IDLE;
            cnt   <= '0;
        end else if (abort) begin
            state <= MULTI_IDLE;
            cnt   <= '0;
        end else if (!freeze) begin
            case (state)
                MULTI_IDLE: begin
                    if (start) begin
                        if (eff == ONE) begin
                            state <= MULTI_DONE;
                        end else begin
                            state <= MULTI_BUSY;
                            cnt   <= eff - ONE;
                        end
                    end
                end
                MULTI_BUSY: begin
                    if (cnt == ONE) begin
                        state <= MULTI_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                MULTI_DONE: state <= MULTI_IDLE;
                default:    state <= MULTI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_pipeline_ctrl.sv
// Central pipeline sequencer: stall priority merge, flush/redirect and performance counters.
module cpu_pipeline_ctrl
    import cpu_defs::*;
#(
    parameter int MULTI_CNT_W = 6,
    parameter int PERF_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    cpu_pipeline_ctrl_if.slave  bus
);

    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    logic   multi_busy;
    logic   multi_stall;
    logic   multi_done;
    Stall_t stall;
    logic   flush;
    logic [31:0] redirect_pc;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_count;

    cpu_multi_seq #(
        .CNT_W (MULTI_CNT_W)
    ) u_multi (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.multi_start),
        .cycles    (bus.multi_cycles),
        .freeze    (bus.stallreq_mem),
        .abort     (bus.flush_req),
        .busy      (multi_busy),
        .stall_req (multi_stall),
        .done      (multi_done)
    );

    // Outputs are forced low during reset even though requests are combinational.
    always_comb begin
        stall       = STALL_NONE;
        flush       = 1'b0;
        redirect_pc = '0;
        if (!rst) begin
            if (bus.flush_req) begin
                flush       = 1'b1;
                redirect_pc = bus.flush_pc;
            end else if (bus.stallreq_mem) begin
                stall = STALL_MEM;
            end else if (multi_stall) begin
                stall = STALL_MULTI;
            end else if (bus.stallreq_id) begin
                stall = STALL_ID;
            end else if (bus.stallreq_if) begin
                stall = STALL_IF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall != STALL_NONE) stall_cycles <= stall_cycles + PERF_ONE;
            if (flush)               flush_count  <= flush_count + PERF_ONE;
        end
    end

    assign bus.stall        = stall;
    assign bus.flush        = flush;
    assign bus.redirect_pc  = redirect_pc;
    assign bus.multi_busy   = multi_busy;
    assign bus.multi_done   = multi_done;
    assign bus.stall_cycles = stall_cycles;
    assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Directed self-checking bench for the pipeline sequencer.
module tb_cpu_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_pipeline_ctrl_if #(.MULTI_CNT_W(6), .PERF_W(32)) bus ();

    cpu_pipeline_ctrl #(.MULTI_CNT_W(6), .PERF_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_sc = 0;
    logic [31:0] exp_fc = 0;

    task automatic clear_reqs();
        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.multi_start  = 1'b0;
        bus.multi_cycles = 6'd0;
        bus.flush_req    = 1'b0;
        bus.flush_pc     = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stallreq_if  = 1'b1;
        bus.stallreq_id  = 1'b1;
        bus.stallreq_mem = 1'b1;
        bus.multi_start  = 1'b1;
        bus.multi_cycles = 6'd5;
        bus.flush_req    = 1'b1;
        bus.flush_pc     = 32'h1234_5678;
        tick();
        tick();
        total++; if (bus.stall !== 5'b00000) $display("FAIL rst_stall got=%b want=00000", bus.stall); else passed++;
        total++; if (bus.flush !== 1'b0) $display("FAIL rst_flush got=%b want=0", bus.flush); else passed++;
        total++; if (bus.redirect_pc !== 32'h0) $display("FAIL rst_redirect got=%h want=0", bus.redirect_pc); else passed++;
        total++; if (bus.multi_busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.multi_busy); else passed++;
        total++; if (bus.multi_done !== 1'b0) $display("FAIL rst_done got=%b want=0", bus.multi_done); else passed++;
        clear_reqs();
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.stall !== 5'b00000) $display("FAIL post_rst_stall got=%b want=00000", bus.stall); else passed++;
        tick();
        total++; if (bus.stall_cycles !== 32'd0) $display("FAIL post_rst_sc got=%0d want=0", bus.stall_cycles); else passed++;
        total++; if (bus.flush_count !== 32'd0) $display("FAIL post_rst_fc got=%0d want=0", bus.flush_count); else passed++;
        total++; if (bus.multi_busy !== 1'b0) $display("FAIL post_rst_busy got=%b want=0", bus.multi_busy); else passed++;
    endtask

    task automatic test_load_use();
        bus.stallreq_id = 1'b1;
        #1;
        total++; if (bus.stall !== 5'b00011) $display("FAIL load_use_stall got=%b want=00011", bus.stall); else passed++;
        tick();
        exp_sc++;
        bus.stallreq_id = 1'b0;
        #1;
        total++; if (bus.stall !== 5'b00000) $display("FAIL load_use_release got=%b want=00000", bus.stall); else passed++;
        total++; if (bus.stall_cycles !== 32'd1) $display("FAIL load_use_sc got=%0d want=1", bus.stall_cycles); else passed++;
    endtask

    task automatic test_multi(input logic [5:0] n);
        int eff;
        eff = (n == 6'd0) ? 1 : int'(n);
        bus.multi_cycles = n;
        bus.multi_start  = 1'b1;
        for (int i = 0; i < eff; i++) begin
            #1;
            total++; if (bus.stall !== 5'b00111) $display("FAIL multi%0d_stall c%0d got=%b want=00111", n, i, bus.stall); else passed++;
            total++; if (bus.multi_busy !== 1'b1) $display("FAIL multi%0d_busy c%0d got=%b want=1", n, i, bus.multi_busy); else passed++;
            total++; if (bus.multi_done !== 1'b0) $display("FAIL multi%0d_early_done c%0d got=%b want=0", n, i, bus.multi_done); else passed++;
            tick();
            exp_sc++;
            bus.multi_start = 1'b0;
        end
        #1;
        total++; if (bus.multi_done !== 1'b1) $display("FAIL multi%0d_done got=%b want=1", n, bus.multi_done); else passed++;
        total++; if (bus.stall !== 5'b00000) $display("FAIL multi%0d_done_stall got=%b want=00000", n, bus.stall); else passed++;
        total++; if (bus.multi_busy !== 1'b0) $display("FAIL multi%0d_done_busy got=%b want=0", n, bus.multi_busy); else passed++;
        tick();
        total++; if (bus.multi_done !== 1'b0) $display("FAIL multi%0d_idle_done got=%b want=0", n, bus.multi_done); else passed++;
        total++; if (bus.stall_cycles !== exp_sc) $display("FAIL multi%0d_sc got=%0d want=%0d", n, bus.stall_cycles, exp_sc); else passed++;
    endtask

    task automatic test_freeze();
        logic       mem_v  [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
        logic [4:0] st_v   [9] = '{5'b00111, 5'b01111, 5'b01111, 5'b00111, 5'b00111,
                                   5'b01111, 5'b01111, 5'b00000, 5'b00000};
        logic       busy_v [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic       done_v [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
        bus.multi_cycles = 6'd3;
        bus.multi_start  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.stallreq_mem = mem_v[i];
            #1;
            total++; if (bus.stall !== st_v[i]) $display("FAIL freeze_stall c%0d got=%b want=%b", i, bus.stall, st_v[i]); else passed++;
            total++; if (bus.multi_busy !== busy_v[i]) $display("FAIL freeze_busy c%0d got=%b want=%b", i, bus.multi_busy, busy_v[i]); else passed++;
            total++; if (bus.multi_done !== done_v[i]) $display("FAIL freeze_done c%0d got=%b want=%b", i, bus.multi_done, done_v[i]); else passed++;
            tick();
            if (st_v[i] != 5'b00000) exp_sc++;
            bus.multi_start = 1'b0;
        end
        bus.stallreq_mem = 1'b0;
        total++; if (bus.stall_cycles !== exp_sc) $display("FAIL freeze_sc got=%0d want=%0d", bus.stall_cycles, exp_sc); else passed++;
    endtask

    task automatic test_start_ignored();
        bus.multi_cycles = 6'd2;
        bus.multi_start  = 1'b1;
        tick(); exp_sc++;
        tick(); exp_sc++;
        #1;
        total++; if (bus.multi_done !== 1'b1) $display("FAIL ign_done got=%b want=1", bus.multi_done); else passed++;
        total++; if (bus.stall !== 5'b00000) $display("FAIL ign_done_stall got=%b want=00000", bus.stall); else passed++;
        tick();
        total++; if (bus.stall !== 5'b00111) $display("FAIL ign_restart_stall got=%b want=00111", bus.stall); else passed++;
        total++; if (bus.multi_done !== 1'b0) $display("FAIL ign_restart_done got=%b want=0", bus.multi_done); else passed++;
        tick(); exp_sc++;
        bus.multi_start = 1'b0;
        tick(); exp_sc++;
        total++; if (bus.multi_done !== 1'b1) $display("FAIL ign_second_done got=%b want=1", bus.multi_done); else passed++;
        tick();
        total++; if (bus.stall_cycles !== exp_sc) $display("FAIL ign_sc got=%0d want=%0d", bus.stall_cycles, exp_sc); else passed++;
    endtask

    task automatic test_flush_abort();
        bus.multi_cycles = 6'd5;
        bus.multi_start  = 1'b1;
        tick(); exp_sc++;
        bus.multi_start = 1'b0;
        bus.flush_req   = 1'b1;
        bus.flush_pc    = 32'hBFC0_0380;
        bus.stallreq_id = 1'b1;
        #1;
        total++; if (bus.flush !== 1'b1) $display("FAIL abort_flush got=%b want=1", bus.flush); else passed++;
        total++; if (bus.redirect_pc !== 32'hBFC0_0380) $display("FAIL abort_redirect got=%h want=bfc00380", bus.redirect_pc); else passed++;
        total++; if (bus.stall !== 5'b00000) $display("FAIL abort_stall got=%b want=00000", bus.stall); else passed++;
        total++; if (bus.multi_done !== 1'b0) $display("FAIL abort_done got=%b want=0", bus.multi_done); else passed++;
        tick(); exp_fc++;
        clear_reqs();
        #1;
        total++; if (bus.flush !== 1'b0) $display("FAIL abort_after_flush got=%b want=0", bus.flush); else passed++;
        total++; if (bus.redirect_pc !== 32'h0) $display("FAIL abort_after_redirect got=%h want=0", bus.redirect_pc); else passed++;
        total++; if (bus.multi_busy !== 1'b0) $display("FAIL abort_after_busy got=%b want=0", bus.multi_busy); else passed++;
        total++; if (bus.flush_count !== 32'd1) $display("FAIL abort_fc got=%0d want=1", bus.flush_count); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++; if (bus.multi_done !== 1'b0 || bus.stall !== 5'b00000) $display("FAIL abort_quiet c%0d done=%b stall=%b want done=0 stall=00000", i, bus.multi_done, bus.stall); else passed++;
            tick();
        end
        bus.flush_req    = 1'b1;
        bus.flush_pc     = 32'h8000_0180;
        bus.multi_start  = 1'b1;
        bus.multi_cycles = 6'd3;
        #1;
        total++; if (bus.multi_busy !== 1'b0) $display("FAIL flush_start_busy got=%b want=0", bus.multi_busy); else passed++;
        tick(); exp_fc++;
        clear_reqs();
        #1;
        total++; if (bus.stall !== 5'b00000) $display("FAIL flush_start_ignored got=%b want=00000", bus.stall); else passed++;
        total++; if (bus.flush_count !== exp_fc) $display("FAIL flush_count got=%0d want=%0d", bus.flush_count, exp_fc); else passed++;
        total++; if (bus.stall_cycles !== exp_sc) $display("FAIL flush_sc got=%0d want=%0d", bus.stall_cycles, exp_sc); else passed++;
    endtask

    task automatic test_priority();
        bus.stallreq_if  = 1'b1;
        bus.stallreq_id  = 1'b1;
        bus.stallreq_mem = 1'b1;
        #1;
        total++; if (bus.stall !== 5'b01111) $display("FAIL prio_all got=%b want=01111", bus.stall); else passed++;
        bus.stallreq_mem = 1'b0;
        #1;
        total++; if (bus.stall !== 5'b00011) $display("FAIL prio_if_id got=%b want=00011", bus.stall); else passed++;
        bus.stallreq_id = 1'b0;
        #1;
        total++; if (bus.stall !== 5'b00001) $display("FAIL prio_if got=%b want=00001", bus.stall); else passed++;
        tick(); exp_sc++;
        clear_reqs();
        #1;
        total++; if (bus.stall_cycles !== exp_sc) $display("FAIL prio_sc got=%0d want=%0d", bus.stall_cycles, exp_sc); else passed++;
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_load_use();
        test_multi(6'd4);
        test_multi(6'd0);
        test_multi(6'd1);
        test_freeze();
        test_start_ignored();
        test_flush_abort();
        test_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
